// File: rtl/dtu_pkg.sv
// dtu_pkg: shared constants and sequencer state type for the dtu frame sequencer
package dtu_pkg;
  localparam int CHAR_W = 7;
  localparam int SEL_W = 2;
  typedef enum logic [2:0] {IDLE, START, TX_WAIT, RX_WAIT, ACK, ACK_WAIT, NEXT, DONE} dtu_seq_state_t;
endpackage

// File: rtl/dtu_seq_timer.sv
// dtu_seq_timer: per-state cycle counter; ports clk, rst, clear (reload to 0), expired (high on the TIMEOUT_CYC-th cycle since clear)
module dtu_seq_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (!expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/dtu_seq.sv
// dtu_seq: frame sequencer owning dtu tx_start/rx_ack, counting pass/error/timeout frames; ports clk, rst, en, start, num_frames, start_sel, sel_incr, tx_busy, rx_ready, rx_error, rx_character1 in; tx_start, tx_character_sel, rx_ack, busy, done, pass_cnt, err_cnt, tmo_cnt out; DTU_SEQ_CHECK_EN adds exp_char0..3 in and last_bad_char out
module dtu_seq #(
  parameter int CNT_W = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CHAR_W = dtu_pkg::CHAR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [dtu_pkg::SEL_W-1:0] start_sel,
  input  logic sel_incr,
  input  logic tx_busy,
  input  logic rx_ready,
  input  logic rx_error,
  input  logic [CHAR_W-1:0] rx_character1,
  output logic tx_start,
  output logic [dtu_pkg::SEL_W-1:0] tx_character_sel,
  output logic rx_ack,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tmo_cnt
`ifdef DTU_SEQ_CHECK_EN
  ,
  input  logic [CHAR_W-1:0] exp_char0,
  input  logic [CHAR_W-1:0] exp_char1,
  input  logic [CHAR_W-1:0] exp_char2,
  input  logic [CHAR_W-1:0] exp_char3,
  output logic [CHAR_W-1:0] last_bad_char
`endif
);
  import dtu_pkg::*;
  dtu_seq_state_t state, nxt;
  logic [CNT_W-1:0] rem;
  logic [SEL_W-1:0] sel;
  logic acc, tmo, tmo_flag, rx_hit, bad, expired;
  assign acc = state == IDLE && start && en;
  assign rx_hit = en && state == RX_WAIT && rx_ready;
  assign tmo = en && expired && ((state == START && !tx_busy) || (state == TX_WAIT && tx_busy) ||
               (state == RX_WAIT && !rx_ready) || (state == ACK_WAIT && rx_ready));
  assign tx_start = state == START;
  assign rx_ack = state == ACK || (state == NEXT && tmo_flag);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign tx_character_sel = sel;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = acc ? (num_frames == '0 ? DONE : START) : IDLE;
      START:    nxt = tx_busy ? TX_WAIT : START;
      TX_WAIT:  nxt = tx_busy ? TX_WAIT : RX_WAIT;
      RX_WAIT:  nxt = rx_ready ? ACK : RX_WAIT;
      ACK:      nxt = ACK_WAIT;
      ACK_WAIT: nxt = rx_ready ? ACK_WAIT : NEXT;
      NEXT:     nxt = rem == CNT_W'(1) ? DONE : START;
      default:  nxt = IDLE;
    endcase
    if (tmo) nxt = NEXT;
    if (!en && state != IDLE) nxt = IDLE;
  end
  dtu_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) timer (
    .clk(clk),
    .rst(rst),
    .clear(nxt != state),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tmo_flag <= 1'b0;
      rem <= '0;
      sel <= '0;
      pass_cnt <= '0;
      err_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= nxt;
      tmo_flag <= tmo;
      pass_cnt <= acc ? '0 : pass_cnt + CNT_W'(rx_hit && !bad && pass_cnt != '1);
      err_cnt <= acc ? '0 : err_cnt + CNT_W'(rx_hit && bad && err_cnt != '1);
      tmo_cnt <= acc ? '0 : tmo_cnt + CNT_W'(tmo && tmo_cnt != '1);
      if (acc) begin
        rem <= num_frames;
        sel <= start_sel;
      end else if (en && state == NEXT) begin
        rem <= rem - CNT_W'(1);
        sel <= sel + SEL_W'(sel_incr);
      end
    end
`ifdef DTU_SEQ_CHECK_EN
  logic [CHAR_W-1:0] exp_char;
  assign exp_char = sel == 2'd0 ? exp_char0 : sel == 2'd1 ? exp_char1 : sel == 2'd2 ? exp_char2 : exp_char3;
  assign bad = rx_error || rx_character1 != exp_char;
  always_ff @(posedge clk)
    if (rst) last_bad_char <= '0;
    else if (rx_hit && bad) last_bad_char <= rx_character1;
`else
  logic unused_char;
  assign unused_char = ^rx_character1;
  assign bad = rx_error;
`endif
endmodule

// File: tb/tb_dtu_seq.sv
// tb_dtu_seq: table-driven scoreboard bench for dtu_seq with a behavioural dtu responder
module tb_dtu_seq;
  localparam int CNT_W = 8;
  localparam int CHAR_W = 7;
  logic clk = 1'b0;
  logic rst, en, start, sel_incr, tx_busy, rx_ready, rx_error;
  logic tx_start, rx_ack, busy, done;
  logic [CNT_W-1:0] num_frames, pass_cnt, err_cnt, tmo_cnt;
  logic [1:0] start_sel, tx_character_sel;
  logic [CHAR_W-1:0] rx_character1;
  logic [CHAR_W-1:0] exp_chars [4];
`ifdef DTU_SEQ_CHECK_EN
  logic [CHAR_W-1:0] last_bad_char;
`endif
  always #5 clk = ~clk;
  dtu_seq #(.CNT_W(CNT_W), .TIMEOUT_CYC(16), .CHAR_W(CHAR_W)) dut (
`ifdef DTU_SEQ_CHECK_EN
    .exp_char0(exp_chars[0]),
    .exp_char1(exp_chars[1]),
    .exp_char2(exp_chars[2]),
    .exp_char3(exp_chars[3]),
    .last_bad_char(last_bad_char),
`endif
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .num_frames(num_frames),
    .start_sel(start_sel),
    .sel_incr(sel_incr),
    .tx_busy(tx_busy),
    .rx_ready(rx_ready),
    .rx_error(rx_error),
    .rx_character1(rx_character1),
    .tx_start(tx_start),
    .tx_character_sel(tx_character_sel),
    .rx_ack(rx_ack),
    .busy(busy),
    .done(done),
    .pass_cnt(pass_cnt),
    .err_cnt(err_cnt),
    .tmo_cnt(tmo_cnt)
  );
  typedef struct {int nf; int ssel; int incr; int stuck; int emask; int pass; int err; int tmo;} vec_t;
  typedef struct {int pass; int err; int tmo; int acks; int txs;} res_t;
  vec_t vecs [5];
  res_t res_q [$];
  int sel_q [$];
  int cmp = 0, bad = 0;
  int acks = 0, txs = 0, done_cnt = 0, fidx = 0, emask = 0;
  bit prev_tx = 1'b0, stuck = 1'b0, force_bad = 1'b0;
  task automatic chk(input string n, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", n, act, exp);
    end
  endtask
  task automatic fail_now(input string n, input int act, input int exp);
    cmp++;
    bad++;
    $display("FAIL %s: got %0d required %0d", n, act, exp);
  endtask
  always @(negedge clk) begin
    int s;
    res_t r;
    if (tx_start && !prev_tx) begin
      txs++;
      if (sel_q.size() == 0) fail_now("tx_sel_unexpected", int'(tx_character_sel), -1);
      else begin
        s = sel_q.pop_front();
        chk("tx_sel", int'(tx_character_sel), s);
      end
    end
    prev_tx = tx_start;
    if (rx_ack) acks++;
    if (done) begin
      done_cnt++;
      if (res_q.size() == 0) fail_now("done_unexpected", done_cnt, done_cnt - 1);
      else begin
        r = res_q.pop_front();
        chk("pass_cnt", int'(pass_cnt), r.pass);
        chk("err_cnt", int'(err_cnt), r.err);
        chk("tmo_cnt", int'(tmo_cnt), r.tmo);
        chk("rx_ack_pulses", acks, r.acks);
        chk("tx_start_pulses", txs, r.txs);
      end
    end
  end
  initial begin
    tx_busy = 1'b0;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    rx_character1 = '0;
    forever begin
      @(posedge clk);
      if (tx_start && !stuck && !rst) begin
        #1 tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        rx_error = emask[fidx];
        rx_character1 = force_bad ? 7'h42 : exp_chars[tx_character_sel];
        for (int i = 0; i < 64; i++) begin
          @(posedge clk);
          if (rx_ack || !busy) break;
        end
        #1;
        rx_ready = 1'b0;
        rx_error = 1'b0;
        fidx++;
      end
    end
  end
  task automatic push_sel(input int ssel, input int incr, input int n);
    int s;
    s = ssel;
    for (int i = 0; i < n; i++) begin
      sel_q.push_back(s);
      if (incr != 0) s = (s + 1) % 4;
    end
  endtask
  task automatic pulse_start(input int nf, input int ssel, input int incr);
    @(negedge clk);
    num_frames = CNT_W'(nf);
    start_sel = 2'(ssel);
    sel_incr = 1'(incr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input vec_t v);
    res_t r;
    int d0;
    stuck = v.stuck != 0;
    emask = v.emask;
    fidx = 0;
    acks = 0;
    txs = 0;
    push_sel(v.ssel, v.incr, v.nf);
    r.pass = v.pass;
    r.err = v.err;
    r.tmo = v.tmo;
    r.acks = v.nf;
    r.txs = v.nf;
    res_q.push_back(r);
    d0 = done_cnt;
    pulse_start(v.nf, v.ssel, v.incr);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    chk("run_done_seen", done_cnt, d0 + 1);
    if (done_cnt == d0) begin
      res_q.delete();
      sel_q.delete();
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    for (int k = 0; k < 4; k++) exp_chars[k] = CHAR_W'(7'h40 + k);
    vecs[0] = '{1, 1, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{6, 3, 1, 0, 0, 6, 0, 0};
    vecs[2] = '{4, 0, 0, 0, 2, 3, 1, 0};
    vecs[3] = '{2, 2, 1, 1, 0, 0, 0, 2};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    num_frames = '0;
    start_sel = '0;
    sel_incr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_rx_ack", int'(rx_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_tmo", int'(tmo_cnt), 0);
    chk("rst_sel", int'(tx_character_sel), 0);
    for (int i = 0; i < 5; i++) run(vecs[i]);
    fidx = 0;
    emask = 0;
    acks = 0;
    txs = 0;
    d0 = done_cnt;
    push_sel(0, 1, 3);
    pulse_start(5, 0, 1);
    for (int i = 0; i < 200 && txs < 1; i++) @(negedge clk);
    pulse_start(1, 2, 1);
    chk("busy_ignored_start", int'(busy), 1);
    for (int i = 0; i < 300 && !(txs == 3 && rx_ready); i++) @(negedge clk);
    chk("abort_reached_frame3", txs, 3);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tx_start", int'(tx_start), 0);
    chk("abort_rx_ack", int'(rx_ack), 0);
    chk("abort_pass", int'(pass_cnt), 2);
    chk("abort_err", int'(err_cnt), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_sel_left", sel_q.size(), 0);
    sel_q.delete();
    en = 1'b1;
    repeat (20) @(negedge clk);
    fidx = 0;
    acks = 0;
    txs = 0;
    d0 = done_cnt;
    push_sel(0, 0, 1);
    pulse_start(3, 0, 0);
    for (int i = 0; i < 200 && pass_cnt != 1; i++) @(negedge clk);
    chk("mrst_pass_before", int'(pass_cnt), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_tx_start", int'(tx_start), 0);
    chk("mrst_rx_ack", int'(rx_ack), 0);
    chk("mrst_pass", int'(pass_cnt), 0);
    repeat (20) @(negedge clk);
    chk("mrst_no_done", done_cnt, d0);
    chk("mrst_sel_left", sel_q.size(), 0);
    sel_q.delete();
`ifdef DTU_SEQ_CHECK_EN
    force_bad = 1'b1;
    run('{1, 1, 0, 0, 0, 0, 1, 0});
    force_bad = 1'b0;
    chk("last_bad_char", int'(last_bad_char), 'h42);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/dtu_seq.md
Name: dtu_seq

Overview:
Frame sequencer for the dtu transmit/receive pair, used in loopback and link-test configurations.
- On a `start` command it issues `num_frames` transmissions, each with a `tx_character_sel` value.
- After each transmission it waits for the receiver to report a character, acknowledges it with `rx_ack`, and classifies the frame as pass, error or timeout.
- It sits between the host/test control logic and the dtu and owns the `tx_start`/`rx_ack` handshakes.

Parameters:
- `CNT_W`, 8: width of `num_frames` and of the pass/error/timeout counters.
- `TIMEOUT_CYC`, 1024: maximum cycles spent in any wait state before the frame is declared timed out.
- `CHAR_W`, 7: dtu character width.

Ports:
- `clk`  in  1  sole clock; the dtu `clk_tx` and `clk_rx` are driven from the same clock.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  block enable; low aborts the run.
- `start`  in  1  one-cycle run request; ignored while `busy`.
- `num_frames`  in  CNT_W  frames per run; sampled on accepted `start`.
- `start_sel`  in  2  first character select; sampled on accepted `start`.
- `sel_incr`  in  1  1: select increments per frame and wraps 3→0; 0: select held fixed.
- `tx_busy`  in  1  from dtu.
- `rx_ready`  in  1  from dtu.
- `rx_error`  in  1  from dtu.
- `rx_character1`  in  CHAR_W  from dtu.
- `tx_start`  out  1  to dtu.
- `tx_character_sel`  out  2  to dtu.
- `rx_ack`  out  1  to dtu.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass_cnt`  out  CNT_W  frames passed in the current/last run.
- `err_cnt`  out  CNT_W  frames failed in the current/last run.
- `tmo_cnt`  out  CNT_W  frames timed out in the current/last run.

Behaviour:
- Reset: all outputs are 0; state is IDLE; internal selector, frame counter and timer are 0.
- Counters:
  - Cleared on an accepted `start`.
  - Saturate at all-ones.
  - Hold their values after `done`, until the next accepted `start`.
- States:
  - IDLE: on `start & en`, latch `num_frames` and `start_sel`, clear the counters, set `busy`. If `num_frames == 0`, go to DONE. Otherwise go to START.
  - START: `tx_start = 1`. Held until `tx_busy == 1` is observed, then go to TX_WAIT.
  - TX_WAIT: `tx_start = 0`. Wait for `tx_busy == 0`, then go to RX_WAIT.
  - RX_WAIT: wait for `rx_ready == 1`. Classify the frame: `rx_error` set → `err_cnt++`; otherwise `pass_cnt++`. Go to ACK.
  - ACK: `rx_ack = 1` for exactly one cycle, then go to ACK_WAIT.
  - ACK_WAIT: wait for `rx_ready == 0`, then go to NEXT.
  - NEXT: decrement the remaining-frame count. If `sel_incr`, advance the selector modulo 4. If frames remain, go to START; otherwise go to DONE.
  - DONE: pulse `done` for one cycle, clear `busy`, go to IDLE.
- Timeout:
  - The timer restarts on every state entry.
  - In START, TX_WAIT, RX_WAIT or ACK_WAIT, reaching `TIMEOUT_CYC` cycles increments `tmo_cnt`.
  - The sequencer then pulses `rx_ack` once (to clear any stale rx flag) and goes to NEXT.
  - A timed-out frame does not count as pass or error.
- `tx_character_sel` is registered and stable from START entry through NEXT of each frame.
- Minimum frame latency: START(1) + TX_WAIT + RX_WAIT + ACK(1) + ACK_WAIT(1) + NEXT(1).
- Boundary conditions:
  - `start` while busy: ignored; no restart.
  - `en` deasserted mid-run: next cycle, go to IDLE. `tx_start` and `rx_ack` go low, `busy` clears, no `done` pulse, counters are retained.
  - `rx_ready` already high on RX_WAIT entry: it is accepted on that cycle.
  - `rx_error` and `rx_ready` rising in the same cycle: counted as error.
  - `rst` mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
Macro: `DTU_SEQ_CHECK_EN`.
- Defined:
  - Adds inputs `exp_char0`..`exp_char3` (CHAR_W each), the expected character per select value.
  - In RX_WAIT, a frame counts as pass only if `!rx_error` and `rx_character1 == exp_char[sel]`; otherwise it counts as error.
  - Adds output `last_bad_char` (CHAR_W): `rx_character1` of the most recent failing frame, 0 at reset.
- Undefined: ports absent; classification uses `rx_error` only.

Decomposition:
- Package `dtu_pkg`:
  - Constants `CHAR_W=7`, `SEL_W=2`.
  - Typedef `dtu_seq_state_t` (IDLE, START, TX_WAIT, RX_WAIT, ACK, ACK_WAIT, NEXT, DONE).
- Sub-module `dtu_seq_timer`:
  - Loadable up-counter with a `clear` input and an `expired` flag at `TIMEOUT_CYC`.
  - Instantiated once.

Test Plan:
1. Loopback to the dtu, `num_frames=1`, `start_sel=1`, `sel_incr=0` → one `tx_start` assertion; `rx_ack` one-cycle pulse after `rx_ready`; `pass_cnt=1`, `err_cnt=0`, `tmo_cnt=0`; `done` pulses once.
2. `num_frames=6`, `start_sel=3`, `sel_incr=1` → `tx_character_sel` sequence 3,0,1,2,3,0; `pass_cnt=6`.
3. Model drives `rx_error=1` on frame 2 of 4 → `err_cnt=1`, `pass_cnt=3`; the run continues to `done`.
4. `tx_busy` stuck at 0, `TIMEOUT_CYC=16`, `num_frames=2` → `tmo_cnt=2`, one `rx_ack` per frame, `done` pulses.
5. `en` dropped during RX_WAIT of frame 3 → IDLE next cycle, `busy=0`, no `done`, counters hold 2 passes; `start` during busy is ignored.
6. With `DTU_SEQ_CHECK_EN`, `exp_char1=0x41`, received `0x42` → `err_cnt=1`, `last_bad_char=0x42`.
